rect_cmd_gen: RTL and testbench

RECT_CMD_GEN -- requirements
Module: rect_cmd_gen

---
 rtl/rect_cmd_gen_if.sv | 26 ++
 rtl/rect_cmd_gen.sv | 141 ++++++++++++++
 tb/tb_rect_cmd_gen.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rect_cmd_gen_if.sv
// Request/command bus between a rectangle requester and rect_cmd_gen.
// The master side issues rectangle requests and owns the FIFO almost-full flag.
interface rect_cmd_gen_if;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  x0;
    logic [7:0]  x1;
    logic [6:0]  y0;
    logic [6:0]  y1;
    logic [2:0]  color;
    logic        commit;
    logic        full;
    logic        we;
    logic [15:0] data;
    logic        busy;

    modport master (
        output req_valid, x0, x1, y0, y1, color, commit, full,
        input  req_ready, we, data, busy
    );

    modport slave (
        input  req_valid, x0, x1, y0, y1, color, commit, full,
        output req_ready, we, data, busy
    );
endinterface

// File: rtl/rect_cmd_gen.sv
// Turns a filled-rectangle request into a stream of draw-command words:
// a row/colour word and a column word per pixel, then an optional commit token.
module rect_cmd_gen #(
    parameter int X_MAX = 159,
    parameter int Y_MAX = 119
) (
    input  logic         clk,
    input  logic         reset,
    rect_cmd_gen_if.slave bus
);

    typedef enum logic [1:0] {IDLE, WORD_A, WORD_B, COMMIT} state_t;

    localparam logic [7:0] X_LIM = 8'(X_MAX);
    localparam logic [6:0] Y_LIM = 7'(Y_MAX);

    state_t      state, state_next;
    logic [7:0]  x_lo, x_hi, x_cnt;
    logic [6:0]  y_hi, y_cnt;
    logic [2:0]  color_l;
    logic        commit_l;
    logic        ready_r, we_r;
    logic [15:0] data_r;

    logic [7:0]  x_lo_next, x_hi_next, x_cnt_next;
    logic [6:0]  y_hi_next, y_cnt_next;
    logic [2:0]  color_next;
    logic        commit_next, we_next;
    logic [15:0] data_next;

    logic [7:0]  cx0, cx1;
    logic [6:0]  cy0, cy1;
    logic        degenerate, accept;

    // Out-of-range bounds are clamped before the empty-rectangle test
    assign cx0        = (bus.x0 > X_LIM) ? X_LIM : bus.x0;
    assign cx1        = (bus.x1 > X_LIM) ? X_LIM : bus.x1;
    assign cy0        = (bus.y0 > Y_LIM) ? Y_LIM : bus.y0;
    assign cy1        = (bus.y1 > Y_LIM) ? Y_LIM : bus.y1;
    assign degenerate = (cx0 > cx1) || (cy0 > cy1);
    assign accept     = bus.req_valid && ready_r;

    assign bus.req_ready = ready_r;
    assign bus.we        = we_r;
    assign bus.data      = data_r;
    assign bus.busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        x_lo_next   = x_lo;
        x_hi_next   = x_hi;
        x_cnt_next  = x_cnt;
        y_hi_next   = y_hi;
        y_cnt_next  = y_cnt;
        color_next  = color_l;
        commit_next = commit_l;
        we_next     = 1'b0;
        data_next   = data_r;
        case (state)
            IDLE: begin
                if (accept) begin
                    x_lo_next   = cx0;
                    x_hi_next   = cx1;
                    x_cnt_next  = cx0;
                    y_hi_next   = cy1;
                    y_cnt_next  = cy0;
                    color_next  = bus.color;
                    commit_next = bus.commit;
                    if (!degenerate)    state_next = WORD_A;
                    else if (bus.commit) state_next = COMMIT;
                end
            end
            WORD_A: begin
                if (!bus.full) begin
                    we_next    = 1'b1;
                    data_next  = {6'b0, color_l, y_cnt};
                    state_next = WORD_B;
                end
            end
            WORD_B: begin
                if (!bus.full) begin
                    we_next   = 1'b1;
                    data_next = {8'b0, x_cnt};
                    if (x_cnt == x_hi) begin
                        if (y_cnt == y_hi) begin
                            state_next = commit_l ? COMMIT : IDLE;
                        end else begin
                            x_cnt_next = x_lo;
                            y_cnt_next = y_cnt + 7'd1;
                            state_next = WORD_A;
                        end
                    end else begin
                        x_cnt_next = x_cnt + 8'd1;
                        state_next = WORD_A;
                    end
                end
            end
            COMMIT: begin
                if (!bus.full) begin
                    we_next    = 1'b1;
                    data_next  = 16'hFFFF;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Ready is registered so it stays low through reset and rises the cycle after
    always_ff @(posedge clk) begin
        if (reset) begin
            x_lo     <= '0;
            x_hi     <= '0;
            x_cnt    <= '0;
            y_hi     <= '0;
            y_cnt    <= '0;
            color_l  <= '0;
            commit_l <= 1'b0;
            we_r     <= 1'b0;
            data_r   <= '0;
            ready_r  <= 1'b0;
        end else begin
            x_lo     <= x_lo_next;
            x_hi     <= x_hi_next;
            x_cnt    <= x_cnt_next;
            y_hi     <= y_hi_next;
            y_cnt    <= y_cnt_next;
            color_l  <= color_next;
            commit_l <= commit_next;
            we_r     <= we_next;
            data_r   <= data_next;
            ready_r  <= (state_next == IDLE);
        end
    end

endmodule

// File: tb/tb_rect_cmd_gen.sv
// Self-checking bench for rect_cmd_gen: directed scenarios plus randomized
// rectangles under random backpressure, compared against a pixel-loop model.
module tb_rect_cmd_gen;

    localparam int X_MAX = 159;
    localparam int Y_MAX = 119;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    int   viol = 0;
    logic full_prev = 1'b0;

    logic [15:0] got[$];
    int          got_cyc[$];
    logic [15:0] exp_q[$];

    rect_cmd_gen_if bus ();

    rect_cmd_gen #(.X_MAX(X_MAX), .Y_MAX(Y_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        full_prev <= bus.full;
    end

    // Word monitor; a write in the cycle after full was seen high is a violation
    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            got.push_back(bus.data);
            got_cyc.push_back(cyc);
            if (full_prev) viol++;
        end
    end

    // Reference: walk the clamped rectangle row by row, column by column
    function automatic void build_expected(input int x0, input int x1, input int y0,
                                           input int y1, input int color, input bit commit);
        int cx0 = (x0 > X_MAX) ? X_MAX : x0;
        int cx1 = (x1 > X_MAX) ? X_MAX : x1;
        int cy0 = (y0 > Y_MAX) ? Y_MAX : y0;
        int cy1 = (y1 > Y_MAX) ? Y_MAX : y1;
        exp_q.delete();
        for (int y = cy0; y <= cy1; y++) begin
            for (int x = cx0; x <= cx1; x++) begin
                exp_q.push_back(16'(color * 128 + y));
                exp_q.push_back(16'(x));
            end
        end
        if (commit) exp_q.push_back(16'hFFFF);
    endfunction

    task automatic clear_capture();
        got.delete();
        got_cyc.delete();
        viol = 0;
    endtask

    task automatic send_req(input int x0, input int x1, input int y0, input int y1,
                            input int color, input bit commit);
        int n = 0;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL req_ready_timeout: got %b expected 1", bus.req_ready);
        end
        bus.x0        = 8'(x0);
        bus.x1        = 8'(x1);
        bus.y0        = 7'(y0);
        bus.y1        = 7'(y1);
        bus.color     = 3'(color);
        bus.commit    = commit;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        accept_cyc    = cyc;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        @(negedge clk);
        #1;
        while (bus.busy !== 1'b0 && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_timeout: busy got %b expected 0", bus.busy);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic wait_words(input int count);
        int n = 0;
        @(negedge clk);
        #1;
        while (got.size() < count && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (got.size() < count) begin
            failures++;
            $display("[TB] FAIL word_wait: got %0d words expected %0d", got.size(), count);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.we !== 1'b0 || bus.data !== 16'h0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_outputs: got we=%b data=%h busy=%b ready=%b expected 0 0000 0 0",
                         bus.we, bus.data, bus.busy, bus.req_ready);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ready_after_reset: got %b expected 1", bus.req_ready);
        end
    endtask

    task automatic test_single_pixel();
        clear_capture();
        exp_q = '{16'h0203, 16'h0005, 16'hFFFF};
        send_req(5, 5, 3, 3, 3'b100, 1'b1);
        wait_idle(50);
        checks++;
        if (got.size() != exp_q.size()) begin
            failures++;
            $display("[TB] FAIL single_len: got %0d expected %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL single_word%0d: got %h expected %h", i, got[i], exp_q[i]);
            end
        end
        if (got.size() == 3) begin
            checks++;
            if (got_cyc[0] != accept_cyc + 1 || got_cyc[2] != got_cyc[0] + 2) begin
                failures++;
                $display("[TB] FAIL single_timing: got first=%0d last=%0d expected first=%0d last=%0d",
                         got_cyc[0], got_cyc[2], accept_cyc + 1, accept_cyc + 3);
            end
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_ready: got %b expected 1", bus.req_ready);
        end
    endtask

    task automatic test_fill_2x2();
        clear_capture();
        exp_q = '{16'h0080, 16'h000A, 16'h0080, 16'h000B, 16'h0081, 16'h000A, 16'h0081, 16'h000B};
        send_req(10, 11, 0, 1, 3'b001, 1'b0);
        wait_idle(50);
        checks++;
        if (got.size() != exp_q.size()) begin
            failures++;
            $display("[TB] FAIL fill_len: got %0d expected %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL fill_word%0d: got %h expected %h", i, got[i], exp_q[i]);
            end
        end
        if (got.size() == 8) begin
            checks++;
            if (got_cyc[7] - got_cyc[0] != 7) begin
                failures++;
                $display("[TB] FAIL fill_throughput: got span %0d expected 7", got_cyc[7] - got_cyc[0]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        clear_capture();
        exp_q = '{16'h0080, 16'h000A, 16'h0080, 16'h000B, 16'h0081, 16'h000A, 16'h0081, 16'h000B};
        send_req(10, 11, 0, 1, 3'b001, 1'b0);
        wait_words(2);
        bus.full = 1'b1;
        held = bus.data;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (bus.we !== 1'b0 || bus.data !== held) begin
                failures++;
                $display("[TB] FAIL bp_stall: got we=%b data=%h expected we=0 data=%h", bus.we, bus.data, held);
            end
        end
        bus.full = 1'b0;
        wait_idle(50);
        checks++;
        if (got.size() != exp_q.size() || viol != 0) begin
            failures++;
            $display("[TB] FAIL bp_len: got %0d words %0d violations expected %0d words 0 violations",
                     got.size(), viol, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL bp_word%0d: got %h expected %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_clamp_degenerate();
        clear_capture();
        send_req(200, 255, 127, 127, 3'b010, 1'b0);
        wait_idle(50);
        checks++;
        if (got.size() != 2) begin
            failures++;
            $display("[TB] FAIL clamp_len: got %0d expected 2", got.size());
        end else begin
            checks++;
            if (got[0] !== 16'h0177 || got[1] !== 16'h009F) begin
                failures++;
                $display("[TB] FAIL clamp_words: got %h %h expected 0177 009f", got[0], got[1]);
            end
        end
        clear_capture();
        send_req(9, 4, 0, 0, 3'b111, 1'b1);
        wait_idle(50);
        checks++;
        if (got.size() != 1) begin
            failures++;
            $display("[TB] FAIL degen_len: got %0d expected 1", got.size());
        end else begin
            checks++;
            if (got[0] !== 16'hFFFF || got_cyc[0] != accept_cyc + 1) begin
                failures++;
                $display("[TB] FAIL degen_token: got %h at %0d expected ffff at %0d", got[0], got_cyc[0], accept_cyc + 1);
            end
        end
    endtask

    task automatic test_reset_midop();
        clear_capture();
        send_req(10, 11, 0, 1, 3'b001, 1'b0);
        wait_words(3);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.we !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL midop_reset: got we=%b busy=%b ready=%b expected 0 0 0",
                         bus.we, bus.busy, bus.req_ready);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bus.req_ready !== 1'b1 || got.size() != 3) begin
            failures++;
            $display("[TB] FAIL midop_abort: got ready=%b words=%0d expected ready=1 words=3",
                     bus.req_ready, got.size());
        end
        clear_capture();
        exp_q = '{16'h0203, 16'h0005, 16'hFFFF};
        send_req(5, 5, 3, 3, 3'b100, 1'b1);
        wait_idle(50);
        checks++;
        if (got.size() != exp_q.size()) begin
            failures++;
            $display("[TB] FAIL midop_len: got %0d expected %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL midop_word%0d: got %h expected %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 25; r++) begin
            int xa = int'($urandom_range(0, 255));
            int xb = xa + int'($urandom_range(0, 3));
            int ya = int'($urandom_range(0, 127));
            int yb = ya + int'($urandom_range(0, 2));
            int col = int'($urandom_range(0, 7));
            bit cm = 1'($urandom_range(0, 1));
            int n = 0;
            if (xb > 255) xb = 255;
            if (yb > 127) yb = 127;
            if ($urandom_range(0, 5) == 0) begin
                int t = xa;
                xa = xb;
                xb = t;
            end
            clear_capture();
            build_expected(xa, xb, ya, yb, col, cm);
            send_req(xa, xb, ya, yb, col, cm);
            while (bus.busy === 1'b1 && n < 500) begin
                bus.full = ($urandom_range(0, 2) == 0);
                @(negedge clk);
                #1;
                n++;
            end
            bus.full = 1'b0;
            wait_idle(20);
            checks++;
            if (got.size() != exp_q.size() || viol != 0) begin
                failures++;
                $display("[TB] FAIL rand%0d_len: got %0d words %0d violations expected %0d words 0 violations",
                         r, got.size(), viol, exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
                checks++;
                if (got[i] !== exp_q[i]) begin
                    failures++;
                    $display("[TB] FAIL rand%0d_word%0d: got %h expected %h", r, i, got[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.x0        = '0;
        bus.x1        = '0;
        bus.y0        = '0;
        bus.y1        = '0;
        bus.color     = '0;
        bus.commit    = 1'b0;
        bus.full      = 1'b0;
        test_reset();
        test_single_pixel();
        test_fill_2x2();
        test_backpressure();
        test_clamp_degenerate();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
